// File: rtl/glove_pkg.sv
// ---------------------------------------------------------------------------
// glove_pkg
// Shared types and constants for the glove sensor front end.
//   fx16_t        : signed Q8.8 sample as delivered to Conv
//   FX_FRAC       : fractional bits of fx16_t
//   N_CH_DEFAULT  : default number of sensor channels per frame
//   N_T_DEFAULT   : default number of time steps held per channel
//   NUM_W         : width of the pre-shifted normalisation numerator
//   state_t       : norm_window sequencing states
// ---------------------------------------------------------------------------
package glove_pkg;

    typedef logic signed [15:0] fx16_t;

    localparam int FX_FRAC      = 8;
    localparam int N_CH_DEFAULT = 4;
    localparam int N_T_DEFAULT  = 10;

    // 17-bit signed difference shifted left by FX_FRAC
    localparam int NUM_W        = 17 + FX_FRAC;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        STORE
    } state_t;

endpackage

// File: rtl/serial_div.sv
// ---------------------------------------------------------------------------
// serial_div
// Unsigned restoring divider, one quotient bit per cycle, MSB first.
// Fixed latency of DVD_W iterations after the start cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load dividend/divisor; iterations begin on the next edge
//   dividend   : DVD_W-bit unsigned dividend
//   divisor    : DVS_W-bit unsigned divisor (0 yields a meaningless result)
//   done       : high during the final iteration cycle; quotient is valid
//                from the cycle after done
//   quotient   : DVD_W-bit unsigned quotient
// ---------------------------------------------------------------------------
module serial_div
    import glove_pkg::*;
#(
    parameter int DVD_W = NUM_W,
    parameter int DVS_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             done,
    output logic [DVD_W-1:0] quotient
);

    localparam int CNT_W = $clog2(DVD_W + 1);

    logic             busy;
    logic [CNT_W-1:0] cnt;
    logic [DVS_W-1:0] rem;
    logic [DVS_W-1:0] dvs;
    logic [DVD_W-1:0] quo;
    logic [DVS_W:0]   trial;
    logic [DVS_W:0]   diff;
    logic             ge;

    // Partial remainder shifted with the next dividend bit; quo doubles as
    // the dividend shift register and the quotient collector.
    always_comb begin
        trial = {rem, quo[DVD_W-1]};
        diff  = trial - {1'b0, dvs};
        ge    = (trial >= {1'b0, dvs});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= CNT_W'(DVD_W);
        end else if (busy) begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) busy <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            rem <= '0;
            quo <= dividend;
            dvs <= divisor;
        end else if (busy) begin
            rem <= ge ? diff[DVS_W-1:0] : trial[DVS_W-1:0];
            quo <= {quo[DVD_W-2:0], ge};
        end
    end

    assign done     = busy && (cnt == CNT_W'(1));
    assign quotient = quo;

endmodule

// File: rtl/norm_window.sv
// ---------------------------------------------------------------------------
// norm_window
// Normalises raw signed sensor samples to Q8.8 as (sample - mean) / std and
// keeps a sliding window of N_T frames per channel for Conv. After every
// frame commit that leaves the window full, o_start pulses for one cycle.
// Optional feature macro: NORM_SAT_EN -- clamp out-of-range quotients to
// 0x7FFF / 0x8000 instead of keeping the low 16 bits.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_valid        : i_sample valid (held by source until accepted)
//   i_sample       : raw signed sample, channels in order 0..N_CH-1
//   i_mean[ch]     : signed per-channel mean, sampled at acceptance
//   i_std[ch]      : unsigned per-channel std, sampled at acceptance
//   o_ready        : block can accept a sample
//   o_data[i]      : Q8.8 window, i = ch*N_T + t, t = N_T-1 newest
//   o_start        : one-cycle pulse, window valid
//   o_ch           : channel index expected for the next sample
// ---------------------------------------------------------------------------
module norm_window
    import glove_pkg::*;
#(
    parameter int N_CH = N_CH_DEFAULT,
    parameter int N_T  = N_T_DEFAULT
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_valid,
    input  logic signed [15:0]        i_sample,
    input  logic signed [15:0]        i_mean [0:N_CH-1],
    input  logic        [15:0]        i_std  [0:N_CH-1],
    output logic                      o_ready,
    output fx16_t                     o_data [0:N_CH*N_T-1],
    output logic                      o_start,
    output logic [$clog2(N_CH)-1:0]   o_ch
);

    localparam int CH_W = $clog2(N_CH);
    localparam int FC_W = $clog2(N_T + 1);

    state_t                  state;
    logic                    neg;
    logic                    dzero;
    logic                    nzero;
    fx16_t                   stage [0:N_CH-1];
    logic [FC_W-1:0]         fcnt;
    logic [FC_W-1:0]         fcnt_nxt;
    logic signed [16:0]      diff;
    logic signed [NUM_W-1:0] num;
    logic [NUM_W-1:0]        mag;
    logic                    accept;
    logic                    div_done;
    logic [NUM_W-1:0]        quot;
    fx16_t                   q;
    logic                    last_ch;

    // Apply sign and reduce the 25-bit magnitude quotient to Q8.8.
    // A zero divisor bypasses the quotient entirely.
    function automatic fx16_t reduce_q(input logic [NUM_W-1:0] qt,
                                       input logic ng,
                                       input logic dz,
                                       input logic nz);
        logic [NUM_W-1:0] sv;
        if (dz) begin
            if (!nz) return 16'h0000;
            return ng ? 16'h8000 : 16'h7FFF;
        end
`ifdef NORM_SAT_EN
        if (!ng && (qt > NUM_W'(32'h7FFF))) return 16'h7FFF;
        if ( ng && (qt > NUM_W'(32'h8000))) return 16'h8000;
`endif
        sv = ng ? (~qt + 1'b1) : qt;
        return fx16_t'(sv[15:0]);
    endfunction

    always_comb begin
        diff     = {i_sample[15], i_sample} - {i_mean[o_ch][15], i_mean[o_ch]};
        num      = {diff, {FX_FRAC{1'b0}}};
        mag      = num[NUM_W-1] ? (~num + 1'b1) : num;
        accept   = (state == IDLE) && i_valid;
        q        = reduce_q(quot, neg, dzero, nzero);
        last_ch  = (o_ch == CH_W'(N_CH - 1));
        fcnt_nxt = (fcnt == FC_W'(N_T)) ? fcnt : fcnt + 1'b1;
    end

    serial_div #(
        .DVD_W (NUM_W),
        .DVS_W (16)
    ) u_div (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .start    (accept),
        .dividend (mag),
        .divisor  (i_std[o_ch]),
        .done     (div_done),
        .quotient (quot)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            o_ready <= 1'b1;
            o_start <= 1'b0;
            o_ch    <= '0;
            fcnt    <= '0;
            neg     <= 1'b0;
            dzero   <= 1'b0;
            nzero   <= 1'b0;
            for (int c = 0; c < N_CH; c++) stage[c] <= '0;
            for (int i = 0; i < N_CH*N_T; i++) o_data[i] <= '0;
        end else begin
            o_start <= 1'b0;
            case (state)
                // accept: capture sign / zero flags; divider loads in parallel
                IDLE: begin
                    if (i_valid) begin
                        neg     <= num[NUM_W-1];
                        nzero   <= (num != '0);
                        dzero   <= (i_std[o_ch] == 16'd0);
                        state   <= DIV;
                        o_ready <= 1'b0;
                    end
                end
                // iterate: divider runs its fixed 25 cycles
                DIV: begin
                    if (div_done) state <= STORE;
                end
                // store: write stage, commit the frame on the last channel
                STORE: begin
                    stage[o_ch] <= q;
                    state       <= IDLE;
                    o_ready     <= 1'b1;
                    if (last_ch) begin
                        o_ch    <= '0;
                        fcnt    <= fcnt_nxt;
                        o_start <= (fcnt_nxt == FC_W'(N_T));
                        for (int c = 0; c < N_CH; c++) begin
                            for (int t = 0; t < N_T - 1; t++)
                                o_data[c*N_T + t] <= o_data[c*N_T + t + 1];
                            // the last channel's stage is being written now
                            o_data[c*N_T + N_T - 1] <= (c == N_CH - 1) ? q : stage[c];
                        end
                    end else begin
                        o_ch <= o_ch + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
